// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - cpu/loader single-port RAM arbiter; MEM_ARB_STATS_EN adds stat counters
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_wait,
  output logic [15:0]       stat_ldr_gnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_LDR} own_t;

  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;
  localparam logic [3:0] LIM    = 4'(STARVE_LIM);

  own_t       own_q, own_d;
  logic       rd_q, rd_d;
  logic [3:0] wait_cnt, wait_cnt_d;
  logic       cpu_rd, cpu_wr, cpu_act, starve, ldr_win;

  assign cpu_rdata = ram_rdata;
  assign ldr_rdata = ram_rdata;
  // Gated by reset so a read granted just before reset never reports valid data.
  assign ldr_rvalid = reset && (own_q == S_LDR) && rd_q;

  always_comb begin
    cpu_rd     = (cpu_mem_cmd == MREAD);
    cpu_wr     = (cpu_mem_cmd == MWRITE);
    cpu_act    = cpu_rd || cpu_wr;
    starve     = (wait_cnt == LIM);
    ldr_win    = reset && ldr_req && (!cpu_act || starve);
    own_d      = S_IDLE;
    rd_d       = 1'b0;
    ldr_gnt    = 1'b0;
    cpu_wait   = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = cpu_mem_addr;
    ram_wdata  = cpu_wdata;
    wait_cnt_d = wait_cnt;
    if (ldr_win) begin
      own_d     = S_LDR;
      rd_d      = !ldr_we;
      ldr_gnt   = 1'b1;
      cpu_wait  = cpu_act;
      ram_we    = ldr_we;
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
    end else if (reset && cpu_act) begin
      own_d  = S_CPU;
      rd_d   = cpu_rd;
      ram_we = cpu_wr;
    end
    if (!ldr_req || ldr_win) begin
      wait_cnt_d = 4'd0;
    end else if (!starve) begin
      wait_cnt_d = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      own_q    <= S_IDLE;
      rd_q     <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      own_q    <= own_d;
      rd_q     <= rd_d;
      wait_cnt <= wait_cnt_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_cpu_wait <= 16'd0;
      stat_ldr_gnt  <= 16'd0;
    end else begin
      if (cpu_wait && (stat_cpu_wait != 16'hFFFF)) begin
        stat_cpu_wait <= stat_cpu_wait + 16'd1;
      end
      if (ldr_gnt && (stat_ldr_gnt != 16'hFFFF)) begin
        stat_ldr_gnt <= stat_ldr_gnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with behavioural reference
module tb_mem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LIM    = 3;
  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  logic              clk;
  logic              reset;
  logic [2:0]        cpu_mem_cmd;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_wait;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_rvalid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]       stat_cpu_wait;
  logic [15:0]       stat_ldr_gnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_wait(stat_cpu_wait), .stat_ldr_gnt(stat_ldr_gnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] preload(input int a);
    case (a)
      5:       return 16'hABCD;
      'h20:    return 16'h2020;
      'h21:    return 16'h2121;
      'h30:    return 16'h5A5A;
      default: return 16'(a) ^ 16'h0F0F;
    endcase
  endfunction

  // Synchronous-read RAM, 1-cycle latency, filled on its first clock.
  logic [DATA_W-1:0] ram [0:511];
  logic              ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= preload(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: priority rules stated as plain arithmetic on a denied-cycle count and a shadow memory.
  initial begin : model
    logic [DATA_W-1:0] shadow [0:511];
    int                denied;
    bit                pend_ldr, pend_cpu, cpu_act, win, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e_rd;
    for (int i = 0; i < 512; i++) shadow[i] = preload(i);
    denied = 0; pend_ldr = 0; pend_cpu = 0; e_rd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_gnt", 32'(ldr_gnt), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_wait", 32'(cpu_wait), 32'd0);
        check("rst_rvalid", 32'(ldr_rvalid), 32'd0);
        denied = 0; pend_ldr = 0; pend_cpu = 0;
      end else begin
        cpu_act = (cpu_mem_cmd == MREAD) || (cpu_mem_cmd == MWRITE);
        win     = ldr_req && (!cpu_act || denied >= LIM);
        e_we    = win ? ldr_we : (cpu_mem_cmd == MWRITE);
        e_addr  = win ? ldr_addr : cpu_mem_addr;
        e_wd    = win ? ldr_wdata : cpu_wdata;
        check("gnt", 32'(ldr_gnt), 32'(win));
        check("wait", 32'(cpu_wait), 32'(win && cpu_act));
        check("we", 32'(ram_we), 32'(e_we));
        check("addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) check("wdata", 32'(ram_wdata), 32'(e_wd));
        check("rvalid", 32'(ldr_rvalid), 32'(pend_ldr));
        if (pend_ldr) check("ldr_rdata", 32'(ldr_rdata), 32'(e_rd));
        if (pend_cpu) check("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
        e_rd     = shadow[e_addr];
        if (e_we) shadow[e_addr] = e_wd;
        pend_ldr = win && !ldr_we;
        pend_cpu = !win && (cpu_mem_cmd == MREAD);
        denied   = (ldr_req && !win) ? ((denied + 1 > LIM) ? LIM : denied + 1) : 0;
      end
    end
  end

  task automatic cyc(input logic rst, input logic [2:0] cmd, input logic [ADDR_W-1:0] ca,
                     input logic [DATA_W-1:0] cw, input logic lr, input logic lw,
                     input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] lwd);
    @(posedge clk); #1;
    reset = rst; cpu_mem_cmd = cmd; cpu_mem_addr = ca; cpu_wdata = cw;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = lwd;
    @(negedge clk);
  endtask

  task automatic starve_run();
    for (int i = 1; i <= 4; i++) begin
      cyc(1, MREAD, 9'h005, 16'h0, 1, 0, 9'h020, 16'h0);
      check("starve_gnt", 32'(ldr_gnt), 32'(i == 4));
      check("starve_wait", 32'(cpu_wait), 32'(i == 4));
    end
    cyc(1, MREAD, 9'h005, 16'h0, 0, 0, 9'h020, 16'h0);
    check("starve_cpu_serviced", 32'(cpu_wait), 32'd0);
    check("starve_rdata", 32'(ldr_rdata), 32'h2020);
  endtask

  initial begin
    reset = 1'b0; cpu_mem_cmd = MNONE; cpu_mem_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;

    repeat (2) begin
      cyc(0, MNONE, 9'h000, 16'h0, 1, 0, 9'h030, 16'h0);
      check("t1_gnt_in_reset", 32'(ldr_gnt), 32'd0);
    end
    cyc(1, MNONE, 9'h000, 16'h0, 1, 0, 9'h030, 16'h0);
    check("t1_gnt_after_reset", 32'(ldr_gnt), 32'd1);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t1_rdata", 32'(ldr_rdata), 32'h5A5A);

    cyc(1, MREAD, 9'h005, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t2_addr", 32'(ram_addr), 32'h005);
    check("t2_wait", 32'(cpu_wait), 32'd0);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t2_rdata", 32'(cpu_rdata), 32'hABCD);

    cyc(1, MNONE, 9'h000, 16'h0, 1, 1, 9'h010, 16'h1234);
    check("t3_gnt", 32'(ldr_gnt), 32'd1);
    check("t3_we", 32'(ram_we), 32'd1);
    cyc(1, MREAD, 9'h010, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t3_we_off", 32'(ram_we), 32'd0);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t3_rdata", 32'(cpu_rdata), 32'h1234);

    starve_run();

    cyc(1, MNONE, 9'h000, 16'h0, 1, 0, 9'h020, 16'h0);
    check("t5_gnt", 32'(ldr_gnt), 32'd1);
    cyc(1, MREAD, 9'h021, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t5_rvalid", 32'(ldr_rvalid), 32'd1);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("t5_rvalid_off", 32'(ldr_rvalid), 32'd0);
    check("t5_cpu_rdata", 32'(cpu_rdata), 32'h2121);

    for (int i = 1; i <= 4; i++) cyc(1, MWRITE, 9'h040, 16'h1111, 1, 1, 9'h040, 16'h2222);
    check("coll_wdata", 32'(ram_wdata), 32'h2222);
    cyc(1, MWRITE, 9'h040, 16'h1111, 0, 0, 9'h000, 16'h0);
    check("coll_retry_we", 32'(ram_we), 32'd1);
    cyc(1, MREAD, 9'h040, 16'h0, 0, 0, 9'h000, 16'h0);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("coll_final", 32'(cpu_rdata), 32'h1111);

    cyc(1, 3'b011, 9'h000, 16'h0, 1, 0, 9'h030, 16'h0);
    check("bad_cmd_gnt", 32'(ldr_gnt), 32'd1);
    check("bad_cmd_wait", 32'(cpu_wait), 32'd0);
    cyc(1, 3'b110, 9'h050, 16'h7777, 0, 0, 9'h000, 16'h0);
    check("bad_cmd_we", 32'(ram_we), 32'd0);

    cyc(1, MNONE, 9'h000, 16'h0, 1, 0, 9'h020, 16'h0);
    check("mid_rst_gnt", 32'(ldr_gnt), 32'd1);
    cyc(0, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("mid_rst_rvalid", 32'(ldr_rvalid), 32'd0);
    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    check("post_rst_rvalid", 32'(ldr_rvalid), 32'd0);

`ifdef MEM_ARB_STATS_EN
    cyc(0, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    starve_run();
    starve_run();
    check("stat_cpu_wait", 32'(stat_cpu_wait), 32'd2);
    check("stat_ldr_gnt", 32'(stat_ldr_gnt), 32'd2);
`endif

    cyc(1, MNONE, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
